spi_slave_byte_if: RTL and testbench

SPI slave byte interface, mode 0 (CPOL=0, CPHA=0), MSB first, running entirely in the i_clk_ILA domain. Oversamples the asynchronous host SCK/CS_n/MOSI lines and serialises the byte presented by the upstream sample-to-byte splitter onto MISO. Emits a one-cycle end-of-byte strobe that advances the splitter. Also deserialises MOSI bytes for the ILA command decoder.

---
 rtl/spi_slave_byte_if.sv | 139 +++++++++++++
 tb/tb_spi_slave_byte_if.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave byte interface: oversamples host SCK/CS_n/MOSI in the ILA clock
// domain, shifts the splitter's byte out on MISO and assembles MOSI bytes.
module spi_slave_byte_if #(
  parameter int unsigned sync_stages = 2
) (
  input  logic       i_clk_ILA,
  input  logic       i_rst_n,
  input  logic       i_sck,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  input  logic [7:0] i_send_byte,
  output logic       o_end_byte_post_edge,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [sync_stages-1:0] sck_sync;
  logic [sync_stages-1:0] cs_sync;
  logic [sync_stages-1:0] mosi_sync_chain;
  logic                   sck_prev;
  logic                   cs_prev;

  logic sck_s, cs_s, mosi_sync;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [0:0]        state, state_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic              load_pending, load_pending_nx;
  logic [BYTE_W-1:0] tx_shift, tx_shift_nx;
  logic [BYTE_W-1:0] rx_shift, rx_shift_nx;
  logic [BYTE_W-1:0] rx_byte_nx;
  logic              strobe_nx;

  // Input synchronisers plus one history register for SCK and CS_n edges
  always_ff @(posedge i_clk_ILA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_sync        <= '0;
      cs_sync         <= '1;
      mosi_sync_chain <= '0;
      sck_prev        <= 1'b0;
      cs_prev         <= 1'b1;
    end else begin
      sck_sync        <= {sck_sync[sync_stages-2:0], i_sck};
      cs_sync         <= {cs_sync[sync_stages-2:0], i_cs_n};
      mosi_sync_chain <= {mosi_sync_chain[sync_stages-2:0], i_mosi};
      sck_prev        <= sck_s;
      cs_prev         <= cs_s;
    end
  end

  assign sck_s     = sck_sync[sync_stages-1];
  assign cs_s      = cs_sync[sync_stages-1];
  assign mosi_sync = mosi_sync_chain[sync_stages-1];

  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign cs_rise  = cs_s & ~cs_prev;

  // Next-state and datapath decisions; deselect wins over any same-cycle SCK edge
  always_comb begin
    state_nx        = state;
    bit_cnt_nx      = bit_cnt;
    load_pending_nx = load_pending;
    tx_shift_nx     = tx_shift;
    rx_shift_nx     = rx_shift;
    rx_byte_nx      = o_rx_byte;
    strobe_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx        = SHIFT;
          tx_shift_nx     = i_send_byte;
          bit_cnt_nx      = '0;
          load_pending_nx = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nx        = IDLE;
          bit_cnt_nx      = '0;
          load_pending_nx = 1'b0;
          rx_shift_nx     = '0;
        end else if (sck_rise) begin
          rx_shift_nx = {rx_shift[BYTE_W-2:0], mosi_sync};
          bit_cnt_nx  = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) begin
            rx_byte_nx      = {rx_shift[BYTE_W-2:0], mosi_sync};
            strobe_nx       = 1'b1;
            load_pending_nx = 1'b1;
          end
        end else if (sck_fall) begin
          if (load_pending) begin
            tx_shift_nx     = i_send_byte;
            load_pending_nx = 1'b0;
          end else begin
            tx_shift_nx = {tx_shift[BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_ILA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= IDLE;
      bit_cnt              <= '0;
      load_pending         <= 1'b0;
      tx_shift             <= '0;
      rx_shift             <= '0;
      o_rx_byte            <= '0;
      o_rx_valid           <= 1'b0;
      o_end_byte_post_edge <= 1'b0;
      o_miso               <= 1'b0;
      o_active             <= 1'b0;
    end else begin
      state                <= state_nx;
      bit_cnt              <= bit_cnt_nx;
      load_pending         <= load_pending_nx;
      tx_shift             <= tx_shift_nx;
      rx_shift             <= rx_shift_nx;
      o_rx_byte            <= rx_byte_nx;
      o_rx_valid           <= strobe_nx;
      o_end_byte_post_edge <= strobe_nx;
      o_miso               <= (state_nx == SHIFT) & tx_shift_nx[BYTE_W-1];
      o_active             <= (state_nx == SHIFT);
    end
  end

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Directed bench for spi_slave_byte_if: a host-side SPI driver, a splitter stand-in
// and a per-cycle monitor scoring strobes and received bytes against a byte queue.
module tb_spi_slave_byte_if;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck, cs_n, mosi;
  logic       miso;
  logic [7:0] send_byte;
  logic       end_byte;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       active;

  int tests  = 0;
  int failed = 0;
  int n_strobe = 0;
  logic prev_strobe = 1'b0;

  logic [7:0] rx_exp_q[$];
  logic [7:0] sp_bytes[$];
  int         sp_reads = 0;

  spi_slave_byte_if #(.sync_stages(2)) dut (
    .i_clk_ILA(clk),
    .i_rst_n(rst_n),
    .i_sck(sck),
    .i_cs_n(cs_n),
    .i_mosi(mosi),
    .o_miso(miso),
    .i_send_byte(send_byte),
    .o_end_byte_post_edge(end_byte),
    .o_rx_byte(rx_byte),
    .o_rx_valid(rx_valid),
    .o_active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: strobe shape, MISO idle level, received-byte scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("valid_eq_end_strobe", 32'(rx_valid), 32'(end_byte));
      if (prev_strobe) chk("strobe_one_cycle", 32'(end_byte), 32'd0);
      if (!active) chk("miso_idle_low", 32'(miso), 32'd0);
      if (rx_valid) begin
        if (rx_exp_q.size() == 0) chk("unexpected_rx_valid", 32'd1, 32'd0);
        else chk("rx_byte_scoreboard", 32'(rx_byte), 32'(rx_exp_q.pop_front()));
      end
      if (end_byte) n_strobe++;
      prev_strobe = end_byte;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // Splitter stand-in: presents its next byte two cycles after each end-of-byte strobe
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && end_byte === 1'b1) begin
        repeat (2) @(negedge clk);
        if (sp_bytes.size() > 0) begin
          send_byte = sp_bytes.pop_front();
          sp_reads++;
        end
      end
    end
  end

  // Host: drive MOSI during SCK low, sample MISO right before each SCK rise
  task automatic xfer_bits(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_b[7-i];
      repeat (HALF) @(negedge clk);
      miso_b = {miso_b[6:0], miso};
      if (i == 7) rx_exp_q.push_back(mosi_b);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("active_after_select", 32'(active), 32'd1);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("active_after_deselect", 32'(active), 32'd0);
    chk("miso_after_deselect", 32'(miso), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int s0;
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; send_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(miso), 32'd0);
    chk("reset_end_byte", 32'(end_byte), 32'd0);
    chk("reset_rx_byte", 32'(rx_byte), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_active", 32'(active), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte: MISO 0xA5 out, MOSI 0x3C in
    send_byte = 8'hA5;
    s0 = n_strobe;
    cs_low();
    xfer_bits(8'h3C, 8, got);
    chk("byte1_miso", 32'(got), 32'hA5);
    chk("byte1_strobes", 32'(n_strobe - s0), 32'd1);
    chk("byte1_rx_byte", 32'(rx_byte), 32'h3C);
    cs_high();

    // Back-to-back bytes from a 24-bit sample 0x123456, LSB byte first
    send_byte = 8'h56;
    sp_bytes.push_back(8'h34);
    sp_bytes.push_back(8'h12);
    sp_reads = 0;
    s0 = n_strobe;
    cs_low();
    xfer_bits(8'h11, 8, got);
    chk("split_byte0", 32'(got), 32'h56);
    xfer_bits(8'h22, 8, got);
    chk("split_byte1", 32'(got), 32'h34);
    xfer_bits(8'h33, 8, got);
    chk("split_byte2", 32'(got), 32'h12);
    cs_high();
    chk("split_strobes", 32'(n_strobe - s0), 32'd3);
    chk("split_reads", 32'(sp_reads), 32'd2);
    chk("split_last_rx", 32'(rx_byte), 32'h33);

    // Abort after 5 rises: nothing reported, next byte starts clean
    send_byte = 8'hC3;
    s0 = n_strobe;
    cs_low();
    xfer_bits(8'hFF, 5, got);
    chk("abort_partial_miso", 32'(got), 32'h18);
    cs_high();
    chk("abort_strobes", 32'(n_strobe - s0), 32'd0);
    chk("abort_rx_hold", 32'(rx_byte), 32'h33);
    send_byte = 8'h96;
    cs_low();
    xfer_bits(8'h5A, 8, got);
    chk("post_abort_miso", 32'(got), 32'h96);
    chk("post_abort_rx", 32'(rx_byte), 32'h5A);
    cs_high();

    // Reset mid-byte clears outputs without waiting for a clock edge
    send_byte = 8'hE7;
    cs_low();
    xfer_bits(8'h00, 3, got);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_active", 32'(active), 32'd0);
    chk("midreset_rx_byte", 32'(rx_byte), 32'd0);
    chk("midreset_miso", 32'(miso), 32'd0);
    cs_n = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte = 8'h81;
    s0 = n_strobe;
    cs_low();
    xfer_bits(8'h7E, 8, got);
    chk("post_reset_miso", 32'(got), 32'h81);
    chk("post_reset_rx", 32'(rx_byte), 32'h7E);
    chk("post_reset_strobes", 32'(n_strobe - s0), 32'd1);
    cs_high();

    // SCK activity while deselected is ignored
    s0 = n_strobe;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    chk("idle_sck_strobes", 32'(n_strobe - s0), 32'd0);
    chk("idle_sck_active", 32'(active), 32'd0);
    chk("idle_sck_rx_hold", 32'(rx_byte), 32'h7E);
    chk("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
